ascon_block_sequencer: RTL and testbench

- Sequences message data into rate-sized blocks for the data organizer stage of the ASCON-128 datapath.
- Pulls 64-bit words from an upstream stream and tracks the remaining message length.
- Issues one block per permutation slot, carrying the raw word, its valid bit count (size_treated_data_r), and a block index (bloc_s).
- Inserts the mandatory padding-only block when the message length is a multiple of the rate.

---
 rtl/ascon_block_sequencer_pkg.sv | 30 +++
 rtl/ascon_block_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_ascon_block_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ascon_block_sequencer_pkg.sv
// Shared types and constants for the ASCON-128 block sequencer.
// Holds the sequencer state encoding, the rate constants and the
// helper that turns a remaining byte count into a block bit size.
package ascon_block_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        PAD   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam int RATE_BYTES = 8;
    localparam int RATE_BITS  = 64;

    // Valid bit count of a block: a full rate when at least RATE_BYTES bytes
    // remain, otherwise the remaining byte count times eight.
    function automatic logic [7:0] size_from_rem(input logic       rem_ge_rate,
                                                 input logic [3:0] rem_low);
        logic [7:0] size_v;
        if (rem_ge_rate) begin
            size_v = 8'(RATE_BITS);
        end else begin
            size_v = {1'b0, rem_low, 3'b000};
        end
        return size_v;
    endfunction

endpackage : ascon_block_sequencer_pkg

// File: rtl/ascon_block_sequencer.sv
// ASCON-128 block sequencer: pulls 64-bit message words from an upstream
// stream and issues one rate-sized block per permutation slot, tagging each
// with its valid bit count, a 4-bit wrapping index and a last flag. When the
// message length is a multiple of the rate, an all-zero padding block of size
// 0 is appended. Every output is driven straight from a register.
module ascon_block_sequencer
    import ascon_block_sequencer_pkg::*;
#(
    parameter int NB_BITS_DATA = 64,
    parameter int LEN_W        = 16
) (
    input  logic                    clock_i,
    input  logic                    resetb_i,
    input  logic                    start_i,
    input  logic [LEN_W-1:0]        msg_len_i,
    input  logic                    din_valid_i,
    output logic                    din_ready_o,
    input  logic [NB_BITS_DATA-1:0] din_i,
    output logic                    blk_valid_o,
    input  logic                    blk_ready_i,
    output logic [NB_BITS_DATA-1:0] blk_data_o,
    output logic [7:0]              blk_size_o,
    output logic [3:0]              blk_idx_o,
    output logic                    blk_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic [LEN_W-1:0] RATE_LEN = LEN_W'(RATE_BYTES);

    seq_state_t              state_r;
    seq_state_t              state_next_s;

    logic [LEN_W-1:0]        rem_r;
    logic [3:0]              idx_r;
    logic [NB_BITS_DATA-1:0] blk_data_r;
    logic [7:0]              blk_size_r;
    logic                    blk_last_r;
    logic                    din_ready_r;
    logic                    blk_valid_r;
    logic                    busy_r;
    logic                    done_r;

    logic [LEN_W-1:0]        rem_next_s;
    logic [3:0]              idx_next_s;
    logic [NB_BITS_DATA-1:0] blk_data_next_s;
    logic [7:0]              blk_size_next_s;
    logic                    blk_last_next_s;
    logic                    din_ready_next_s;
    logic                    blk_valid_next_s;
    logic                    busy_next_s;
    logic                    done_next_s;

    logic                    din_fire_s;
    logic                    blk_fire_s;
    logic                    rem_gt_rate_s;
    logic                    rem_eq_rate_s;
    logic                    rem_ge_rate_s;
    logic                    len_zero_s;

    assign din_fire_s    = din_ready_r & din_valid_i;
    assign blk_fire_s    = blk_valid_r & blk_ready_i;
    assign rem_gt_rate_s = (rem_r > RATE_LEN);
    assign rem_eq_rate_s = (rem_r == RATE_LEN);
    assign rem_ge_rate_s = rem_gt_rate_s | rem_eq_rate_s;
    assign len_zero_s    = (msg_len_i == {LEN_W{1'b0}});

    // State register.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; remaining length is compared before it is reduced.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = len_zero_s ? PAD : FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (din_fire_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            ISSUE: begin
                if (!blk_fire_s) begin
                    state_next_s = ISSUE;
                end else if (rem_gt_rate_s) begin
                    state_next_s = FETCH;
                end else if (rem_eq_rate_s) begin
                    state_next_s = PAD;
                end else begin
                    state_next_s = DONE;
                end
            end
            PAD: begin
                if (blk_fire_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = PAD;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Next values of the datapath and of the registered handshake/status outputs.
    always_comb begin
        rem_next_s       = rem_r;
        idx_next_s       = idx_r;
        blk_data_next_s  = blk_data_r;
        blk_size_next_s  = blk_size_r;
        blk_last_next_s  = blk_last_r;
        din_ready_next_s = (state_next_s == FETCH);
        blk_valid_next_s = (state_next_s == ISSUE) || (state_next_s == PAD);
        busy_next_s      = (state_next_s != IDLE);
        done_next_s      = (state_next_s == DONE);
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    rem_next_s = msg_len_i;
                    idx_next_s = 4'd0;
                    if (len_zero_s) begin
                        blk_data_next_s = {NB_BITS_DATA{1'b0}};
                        blk_size_next_s = 8'd0;
                        blk_last_next_s = 1'b1;
                    end else begin
                        blk_last_next_s = blk_last_r;
                    end
                end else begin
                    rem_next_s = rem_r;
                end
            end
            FETCH: begin
                if (din_fire_s) begin
                    blk_data_next_s = din_i;
                    blk_size_next_s = size_from_rem(rem_ge_rate_s, rem_r[3:0]);
                    blk_last_next_s = ~rem_ge_rate_s;
                end else begin
                    blk_data_next_s = blk_data_r;
                end
            end
            ISSUE: begin
                if (blk_fire_s) begin
                    idx_next_s = idx_r + 4'd1;
                    if (rem_gt_rate_s) begin
                        rem_next_s = rem_r - RATE_LEN;
                    end else if (rem_eq_rate_s) begin
                        rem_next_s      = {LEN_W{1'b0}};
                        blk_data_next_s = {NB_BITS_DATA{1'b0}};
                        blk_size_next_s = 8'd0;
                        blk_last_next_s = 1'b1;
                    end else begin
                        rem_next_s = rem_r;
                    end
                end else begin
                    idx_next_s = idx_r;
                end
            end
            PAD: begin
                if (blk_fire_s) begin
                    idx_next_s = idx_r + 4'd1;
                end else begin
                    idx_next_s = idx_r;
                end
            end
            DONE: begin
                rem_next_s = rem_r;
            end
            default: begin
                rem_next_s      = {LEN_W{1'b0}};
                idx_next_s      = 4'd0;
                blk_data_next_s = {NB_BITS_DATA{1'b0}};
                blk_size_next_s = 8'd0;
                blk_last_next_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything and aborts a message.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            rem_r       <= {LEN_W{1'b0}};
            idx_r       <= 4'd0;
            blk_data_r  <= {NB_BITS_DATA{1'b0}};
            blk_size_r  <= 8'd0;
            blk_last_r  <= 1'b0;
            din_ready_r <= 1'b0;
            blk_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            rem_r       <= rem_next_s;
            idx_r       <= idx_next_s;
            blk_data_r  <= blk_data_next_s;
            blk_size_r  <= blk_size_next_s;
            blk_last_r  <= blk_last_next_s;
            din_ready_r <= din_ready_next_s;
            blk_valid_r <= blk_valid_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
        end
    end

    assign din_ready_o = din_ready_r;
    assign blk_valid_o = blk_valid_r;
    assign blk_data_o  = blk_data_r;
    assign blk_size_o  = blk_size_r;
    assign blk_idx_o   = idx_r;
    assign blk_last_o  = blk_last_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule : ascon_block_sequencer

// File: tb/tb_ascon_block_sequencer.sv
// Self-checking bench for ascon_block_sequencer. A message-level model builds
// the expected block list (data, size, index, last) from the message length
// and the random words; the bench drives randomized stalls and compares every
// block handshake, hold stability, done timing and handshake counts.
module tb_ascon_block_sequencer;

    logic        clk;
    logic        resetb;
    logic        start;
    logic [15:0] msg_len;
    logic        din_valid;
    logic        din_ready_o;
    logic [63:0] din;
    logic        blk_valid_o;
    logic        blk_ready;
    logic [63:0] blk_data_o;
    logic [7:0]  blk_size_o;
    logic [3:0]  blk_idx_o;
    logic        blk_last_o;
    logic        busy_o;
    logic        done_o;

    int tests_run;
    int tests_failed;

    ascon_block_sequencer #(.NB_BITS_DATA(64), .LEN_W(16)) dut (
        .clock_i     (clk),
        .resetb_i    (resetb),
        .start_i     (start),
        .msg_len_i   (msg_len),
        .din_valid_i (din_valid),
        .din_ready_o (din_ready_o),
        .din_i       (din),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready),
        .blk_data_o  (blk_data_o),
        .blk_size_o  (blk_size_o),
        .blk_idx_o   (blk_idx_o),
        .blk_last_o  (blk_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one message; up_pct/dn_pct are stall percentages, hold forces
    // blk_ready low for that many cycles of blk_valid, noise injects start pulses.
    task automatic run_msg(input int len, input int up_pct, input int dn_pct,
                           input int hold, input bit noise);
        logic [63:0] words[$];
        logic [63:0] exp_data[$];
        int          exp_size[$];
        bit          exp_last[$];
        int          nwords, nblk, blk_seen, din_seen, wptr, cyc, hold_left;
        bit          saw_ready, done_seen, din_fire, blk_fire, stalled;
        logic [76:0] held;
        nwords = (len + 7) / 8;
        for (int k = 0; k < nwords; k++) begin
            int rb;
            logic [63:0] w;
            w = {$urandom, $urandom};
            rb = len - 8 * k;
            words.push_back(w);
            exp_data.push_back(w);
            exp_size.push_back(rb >= 8 ? 64 : rb * 8);
            exp_last.push_back(rb < 8);
        end
        if (len % 8 == 0) begin
            exp_data.push_back(64'd0);
            exp_size.push_back(0);
            exp_last.push_back(1'b1);
        end
        nblk = exp_data.size();
        blk_seen = 0; din_seen = 0; wptr = 0; cyc = 0; hold_left = hold;
        saw_ready = 1'b0; done_seen = 1'b0; stalled = 1'b0; held = '0;

        start = 1'b1;
        msg_len = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        check("din_ready_after_start", 64'(din_ready_o), 64'(len > 0));

        while (!done_seen && cyc < 3000) begin
            din_valid = ($urandom_range(99) >= 32'(up_pct));
            din = (wptr < nwords) ? words[wptr] : {$urandom, $urandom};
            if (hold_left > 0 && blk_valid_o) begin
                blk_ready = 1'b0;
                hold_left--;
            end else begin
                blk_ready = ($urandom_range(99) >= 32'(dn_pct));
            end
            start = noise ? ($urandom_range(3) == 0) : 1'b0;
            msg_len = 16'($urandom);
            if (din_ready_o) saw_ready = 1'b1;
            din_fire = din_ready_o && din_valid;
            blk_fire = blk_valid_o && blk_ready;
            if (blk_fire) begin
                if (blk_seen < nblk) begin
                    check("blk_data", blk_data_o, exp_data[blk_seen]);
                    check("blk_size", 64'(blk_size_o), 64'(exp_size[blk_seen]));
                    check("blk_idx", 64'(blk_idx_o), 64'(blk_seen % 16));
                    check("blk_last", 64'(blk_last_o), 64'(exp_last[blk_seen]));
                end else begin
                    check("extra_block", 64'(blk_seen), 64'(nblk - 1));
                end
                blk_seen++;
            end
            stalled = blk_valid_o && !blk_ready;
            held = {blk_data_o, blk_size_o, blk_idx_o, blk_last_o};
            @(posedge clk); #1;
            cyc++;
            if (din_fire) begin
                wptr++;
                din_seen++;
            end
            check("done_timing", 64'(done_o), 64'(blk_fire && blk_seen == nblk));
            if (stalled) begin
                check("hold_valid", 64'(blk_valid_o), 64'd1);
                check("hold_fields", {blk_data_o[51:0], blk_size_o, blk_idx_o},
                      {held[64:13], held[12:1]});
                check("hold_upper", {51'd0, blk_data_o[63:52], blk_last_o},
                      {51'd0, held[76:65], held[0]});
            end
            if (done_o) done_seen = 1'b1;
        end
        start = 1'b0;
        din_valid = 1'b0;
        check("finished_in_budget", 64'(done_seen), 64'd1);
        check("block_count", 64'(blk_seen), 64'(nblk));
        check("din_handshakes", 64'(din_seen), 64'(nwords));
        check("din_ready_seen", 64'(saw_ready), 64'(len > 0));

        // A start arriving in DONE must be ignored.
        start = 1'b1;
        msg_len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_after_done", {60'd0, busy_o, done_o, din_ready_o, blk_valid_o}, 64'd0);
    endtask

    initial begin
        bit found;
        tests_run = 0;
        tests_failed = 0;
        resetb = 1'b0;
        start = 1'b0;
        msg_len = 16'd0;
        din_valid = 1'b0;
        din = 64'd0;
        blk_ready = 1'b0;
        #3;
        check("reset_data", blk_data_o, 64'd0);
        check("reset_ctrl", {47'd0, din_ready_o, blk_valid_o, blk_size_o, blk_idx_o,
                             blk_last_o, busy_o, done_o}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {62'd0, busy_o, din_ready_o}, 64'd0);

        run_msg(20, 0, 0, 0, 1'b0);
        run_msg(16, 0, 0, 0, 1'b0);
        run_msg(0, 0, 0, 0, 1'b0);
        run_msg(5, 0, 0, 10, 1'b0);
        run_msg(200, 10, 10, 0, 1'b1);

        // Reset while block 1 is offered downstream.
        start = 1'b1;
        msg_len = 16'd20;
        @(posedge clk); #1;
        start = 1'b0;
        din_valid = 1'b1;
        blk_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            din = {$urandom, $urandom};
            if (blk_valid_o && blk_idx_o == 4'd1) begin
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("reached_block1", 64'(found), 64'd1);
        #2;
        resetb = 1'b0;
        #1;
        check("midreset_data", blk_data_o, 64'd0);
        check("midreset_ctrl", {47'd0, din_ready_o, blk_valid_o, blk_size_o, blk_idx_o,
                                blk_last_o, busy_o, done_o}, 64'd0);
        din_valid = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        @(posedge clk); #1;
        check("idle_after_midreset", {62'd0, busy_o, blk_valid_o}, 64'd0);
        run_msg(3, 0, 0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            run_msg($urandom_range(0, 60), $urandom_range(0, 50), $urandom_range(0, 50),
                    $urandom_range(0, 3), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_ascon_block_sequencer
